// File: rtl/ring_stop_pkg.sv
// Shared ring definitions: slot types, header layout and ring stop states.
// Imported by the ring stop and the message tracker.
package ring_stop_pkg;

  localparam logic [3:0] SLOT_TOKEN   = 4'd1;
  localparam logic [3:0] SLOT_NULL    = 4'd7;
  localparam logic [3:0] SLOT_MESSAGE = 4'd8;

  localparam int DEST_LSB = 14;
  localparam int SRC_LSB  = 10;
  localparam int TYPE_LSB = 6;
  localparam int LEN_LSB  = 0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_PASS = 2'd1,
    ST_HOLD = 2'd2
  } stop_state_e;

  function automatic logic [3:0] hdrDest(input logic [31:0] w);
    return w[DEST_LSB +: 4];
  endfunction

  function automatic logic [3:0] hdrSrc(input logic [31:0] w);
    return w[SRC_LSB +: 4];
  endfunction

  function automatic logic [3:0] hdrType(input logic [31:0] w);
    return w[TYPE_LSB +: 4];
  endfunction

  function automatic logic [5:0] hdrLen(input logic [31:0] w);
    return w[LEN_LSB +: 6];
  endfunction

endpackage

// File: rtl/ring_msg_tracker.sv
// Follows message boundaries on a slot stream and decides whether
// the current slot belongs to a message addressed to this core.
module ring_msg_tracker
  import ring_stop_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] whichCore,
  input  logic [3:0] slotType,
  input  logic [3:0] source,
  input  logic [3:0] dest,
  input  logic [3:0] src,
  input  logic [5:0] len,
  output logic       isHeader,
  output logic       stripNow
);

  logic [5:0] inLen;
  logic       strip;
  logic       stripHdr;

  assign isHeader = (inLen == 6'd0) && (slotType == SLOT_MESSAGE);

  // Our own broadcast comes back with dest==src and our source tag.
  assign stripHdr = ((dest == whichCore) && (src != whichCore)) ||
                    ((dest == src) && (source == whichCore));

  assign stripNow = isHeader ? stripHdr :
                    ((inLen != 6'd0) && strip);

  always_ff @(posedge clock) begin
    if (reset) begin
      inLen <= 6'd0;
      strip <= 1'b0;
    end else if (isHeader) begin
      inLen <= len;
      strip <= stripHdr;
    end else if (inLen != 6'd0) begin
      inLen <= inLen - 6'd1;
    end
  end

endmodule

// File: rtl/ring_stop.sv
// Ring stop: registers the slot stream, strips delivered messages
// and lends the circulating token to the Messenger.
module ring_stop
  import ring_stop_pkg::*;
#(
  parameter bit INIT_TOKEN = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  whichCore,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  input  logic [31:0] msgrRingOut,
  input  logic [3:0]  msgrSlotTypeOut,
  input  logic [3:0]  msgrSourceOut,
  input  logic        msgrDriveRing,
  input  logic        msgrWantsToken,
  output logic        msgrAcquireToken,
  output logic        collision
);

  stop_state_e state, nxtState;
  logic [31:0] nxtData;
  logic [3:0]  nxtType;
  logic [3:0]  nxtSrc;
  logic        nxtColl;
  logic        isHeader;
  logic        stripNow;

  ring_msg_tracker tracker (
    .clock    (clock),
    .reset    (reset),
    .whichCore(whichCore),
    .slotType (SlotTypeIn),
    .source   (SourceIn),
    .dest     (hdrDest(RingIn)),
    .src      (hdrSrc(RingIn)),
    .len      (hdrLen(RingIn)),
    .isHeader (isHeader),
    .stripNow (stripNow)
  );

  always_comb begin
    nxtState         = state;
    nxtData          = RingIn;
    nxtType          = SlotTypeIn;
    nxtSrc           = SourceIn;
    nxtColl          = 1'b0;
    msgrAcquireToken = 1'b0;
    if (stripNow) begin
      nxtData = 32'd0;
      nxtType = SLOT_NULL;
      nxtSrc  = 4'd0;
    end
    unique case (state)
      ST_INIT: begin
        nxtState = ST_PASS;
        if (INIT_TOKEN) begin
          nxtData = 32'd0;
          nxtType = SLOT_TOKEN;
          nxtSrc  = whichCore;
        end
      end
      ST_PASS: begin
        if ((SlotTypeIn == SLOT_TOKEN) && msgrWantsToken && !reset) begin
          msgrAcquireToken = 1'b1;
          nxtData  = msgrRingOut;
          nxtType  = msgrSlotTypeOut;
          nxtSrc   = msgrSourceOut;
          nxtState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Whatever arrives here is dropped; only Null is harmless.
        nxtColl = (SlotTypeIn == SLOT_MESSAGE) ||
                  (SlotTypeIn == SLOT_TOKEN);
        if (msgrDriveRing) begin
          nxtData = msgrRingOut;
          nxtType = msgrSlotTypeOut;
          nxtSrc  = msgrSourceOut;
        end else begin
          nxtData  = 32'd0;
          nxtType  = SLOT_TOKEN;
          nxtSrc   = whichCore;
          nxtState = ST_PASS;
        end
      end
      default: nxtState = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INIT;
      RingOut     <= 32'd0;
      SlotTypeOut <= SLOT_NULL;
      SourceOut   <= 4'd0;
      collision   <= 1'b0;
    end else begin
      state       <= nxtState;
      RingOut     <= nxtData;
      SlotTypeOut <= nxtType;
      SourceOut   <= nxtSrc;
      collision   <= nxtColl;
    end
  end

  logic unusedHdr;
  assign unusedHdr = isHeader;

endmodule

// File: tb/tb_ring_stop.sv
// Directed vector bench for ring_stop with a token-injecting stop
// on core 3.
module tb_ring_stop;

  localparam logic [3:0] TK = 4'd1;
  localparam logic [3:0] NL = 4'd7;
  localparam logic [3:0] MS = 4'd8;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  whichCore;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SourceIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut;
  logic [3:0]  SourceOut;
  logic [31:0] msgrRingOut;
  logic [3:0]  msgrSlotTypeOut;
  logic [3:0]  msgrSourceOut;
  logic        msgrDriveRing;
  logic        msgrWantsToken;
  logic        msgrAcquireToken;
  logic        collision;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clock = ~clock;

  ring_stop #(.INIT_TOKEN(1'b1)) dut (
    .clock           (clock),
    .reset           (reset),
    .whichCore       (whichCore),
    .RingIn          (RingIn),
    .SlotTypeIn      (SlotTypeIn),
    .SourceIn        (SourceIn),
    .RingOut         (RingOut),
    .SlotTypeOut     (SlotTypeOut),
    .SourceOut       (SourceOut),
    .msgrRingOut     (msgrRingOut),
    .msgrSlotTypeOut (msgrSlotTypeOut),
    .msgrSourceOut   (msgrSourceOut),
    .msgrDriveRing   (msgrDriveRing),
    .msgrWantsToken  (msgrWantsToken),
    .msgrAcquireToken(msgrAcquireToken),
    .collision       (collision)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  ty;
    logic [31:0] d;
    logic [3:0]  s;
    logic        want;
    logic        drv;
    logic [3:0]  mTy;
    logic [31:0] mD;
    logic [3:0]  mS;
    logic        eG;
    logic [3:0]  eTy;
    logic [31:0] eD;
    logic [3:0]  eS;
    logic        eC;
  } vec_t;

  vec_t q[$];

  function automatic logic [31:0] hdr(input logic [3:0] dst,
                                      input logic [3:0] sr,
                                      input logic [5:0] ln);
    logic [31:0] w;
    w = 32'd0;
    w[17:14] = dst;
    w[13:10] = sr;
    w[9:6]   = 4'd8;
    w[5:0]   = ln;
    return w;
  endfunction

  // Ring-only vector: Messenger idle.
  function automatic vec_t rv(input logic rst, input logic [3:0] ty,
    input logic [31:0] d, input logic [3:0] s,
    input logic [3:0] eTy, input logic [31:0] eD, input logic [3:0] eS,
    input logic eC);
    vec_t v;
    v = '{rst, ty, d, s, 1'b0, 1'b0, NL, 32'd0, 4'd0,
          1'b0, eTy, eD, eS, eC};
    return v;
  endfunction

  // Vector with the Messenger active.
  function automatic vec_t mv(input logic [3:0] ty, input logic [31:0] d,
    input logic [3:0] s, input logic want, input logic drv,
    input logic [3:0] mTy, input logic [31:0] mD, input logic eG,
    input logic [3:0] eTy, input logic [31:0] eD, input logic [3:0] eS,
    input logic eC);
    vec_t v;
    v = '{1'b0, ty, d, s, want, drv, mTy, mD, 4'd3,
          eG, eTy, eD, eS, eC};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset           = v.rst;
    SlotTypeIn      = v.ty;
    RingIn          = v.d;
    SourceIn        = v.s;
    msgrWantsToken  = v.want;
    msgrDriveRing   = v.drv;
    msgrSlotTypeOut = v.mTy;
    msgrRingOut     = v.mD;
    msgrSourceOut   = v.mS;
    #1;
    chk({tag, ".grant"}, {31'd0, msgrAcquireToken}, {31'd0, v.eG});
    @(posedge clock);
    #1;
    chk({tag, ".type"}, {28'd0, SlotTypeOut}, {28'd0, v.eTy});
    chk({tag, ".data"}, RingOut, v.eD);
    chk({tag, ".src"}, {28'd0, SourceOut}, {28'd0, v.eS});
    chk({tag, ".coll"}, {31'd0, collision}, {31'd0, v.eC});
  endtask

  task automatic runQ(input string tag);
    for (int i = 0; i < q.size(); i++)
      apply(q[i], $sformatf("%s%0d", tag, i));
    q.delete();
  endtask

  initial begin
    whichCore = 4'd3;
    reset = 1'b1;
    SlotTypeIn = NL; RingIn = 0; SourceIn = 0;
    msgrWantsToken = 0; msgrDriveRing = 0;
    msgrSlotTypeOut = NL; msgrRingOut = 0; msgrSourceOut = 0;
    @(posedge clock);
    #1;

    // Reset with a token present: no grant, reset outputs.
    q.push_back(mv(TK, 0, 3, 1, 0, MS, 32'h77, 0, NL, 0, 0, 0));
    q[0].rst = 1'b1;
    q.push_back(rv(1, NL, 0, 0, NL, 0, 0, 0));
    // Injected token, then a re-entering token forwarded.
    q.push_back(rv(0, NL, 0, 0, TK, 0, 3, 0));
    q.push_back(rv(0, TK, 0, 3, TK, 0, 3, 0));
    q.push_back(rv(0, NL, 0, 0, NL, 0, 0, 0));
    // Delivered message stripped; next message forwarded.
    q.push_back(rv(0, MS, hdr(3, 5, 2), 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, 32'hAAAA, 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, 32'hBBBB, 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, hdr(6, 5, 1), 5, MS, hdr(6, 5, 1), 5, 0));
    q.push_back(rv(0, MS, 32'h1234, 5, MS, 32'h1234, 5, 0));
    // Own broadcast stripped, foreign broadcast forwarded.
    q.push_back(rv(0, MS, hdr(3, 3, 1), 3, NL, 0, 0, 0));
    q.push_back(rv(0, MS, 32'h55, 3, NL, 0, 0, 0));
    q.push_back(rv(0, MS, hdr(3, 3, 1), 4, MS, hdr(3, 3, 1), 4, 0));
    q.push_back(rv(0, MS, 32'h66, 4, MS, 32'h66, 4, 0));
    // Zero-length headers: only the header is affected.
    q.push_back(rv(0, MS, hdr(3, 5, 0), 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, hdr(6, 2, 0), 2, MS, hdr(6, 2, 0), 2, 0));
    runQ("v");

    // Grant, header plus three payload words, token release.
    q.push_back(mv(TK, 0, 3, 1, 0, MS, hdr(7, 3, 3), 1, MS, hdr(7, 3, 3), 3, 0));
    q.push_back(mv(NL, 0, 0, 1, 1, MS, 32'h101, 0, MS, 32'h101, 3, 0));
    q.push_back(mv(NL, 0, 0, 1, 1, MS, 32'h102, 0, MS, 32'h102, 3, 0));
    q.push_back(mv(NL, 0, 0, 1, 1, MS, 32'h103, 0, MS, 32'h103, 3, 0));
    q.push_back(mv(NL, 0, 0, 0, 0, NL, 0, 0, TK, 0, 3, 0));
    q.push_back(rv(0, NL, 0, 0, NL, 0, 0, 0));
    // Incoming message overwritten in HOLD.
    q.push_back(mv(TK, 0, 3, 1, 0, MS, hdr(7, 3, 1), 1, MS, hdr(7, 3, 1), 3, 0));
    q.push_back(mv(MS, hdr(9, 8, 0), 8, 0, 1, MS, 32'h201, 0, MS, 32'h201, 3, 1));
    q.push_back(mv(NL, 0, 0, 0, 0, NL, 0, 0, TK, 0, 3, 0));
    // Token arriving in HOLD: dropped, flagged, never granted.
    q.push_back(mv(TK, 0, 3, 1, 0, MS, hdr(7, 3, 0), 1, MS, hdr(7, 3, 0), 3, 0));
    q.push_back(mv(TK, 0, 3, 1, 0, NL, 0, 0, TK, 0, 3, 1));
    q.push_back(mv(NL, 0, 0, 1, 0, NL, 0, 0, NL, 0, 0, 0));
    runQ("g");

    // Maximum length message: 63 payloads stripped, then idle.
    q.push_back(rv(0, MS, hdr(3, 5, 63), 5, NL, 0, 0, 0));
    for (int i = 0; i < 63; i++)
      q.push_back(rv(0, MS, hdr(3, 5, 6'(i)), 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, hdr(6, 5, 0), 5, MS, hdr(6, 5, 0), 5, 0));
    runQ("l");

    // Reset in the middle of a strip, then forwarding and a
    // zero-length grant.
    q.push_back(rv(0, MS, hdr(3, 5, 5), 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, 32'h1, 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, 32'h2, 5, NL, 0, 0, 0));
    q.push_back(rv(1, MS, 32'h3, 5, NL, 0, 0, 0));
    q.push_back(rv(0, MS, 32'hDEAD0000, 5, TK, 0, 3, 0));
    q.push_back(rv(0, MS, 32'hBEEF0000, 5, MS, 32'hBEEF0000, 5, 0));
    q.push_back(mv(TK, 0, 3, 1, 0, MS, hdr(6, 3, 0), 1, MS, hdr(6, 3, 0), 3, 0));
    q.push_back(mv(NL, 0, 0, 0, 0, NL, 0, 0, TK, 0, 3, 0));
    q.push_back(rv(0, NL, 0, 0, NL, 0, 0, 0));
    runQ("r");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
